// File: rtl/debounce_arbiter.sv
// debounce_arbiter: multi-channel switch debouncer that shares one delay
// counter among N_CH channels. Each channel runs its own debounce FSM and a
// round-robin arbiter hands the single timer to one waiting channel at a time.
// Optional build macro: DEBOUNCE_ARB_SYNC_EN adds a 2-flop input synchronizer
// per channel (all latencies grow by 2 cycles). Without it, the inputs must
// already be synchronous to clk_50MHz_i.
module debounce_arbiter #(
    parameter int N_CH    = 4,
    parameter int CNT_MAX = 1500000,
    parameter int CNT_W   = 21
) (
    input  logic            clk_50MHz_i,
    input  logic            rst_async_la_i,
    input  logic [N_CH-1:0] sw_noisy_i,
    output logic [N_CH-1:0] sw_clean_o,
    output logic [N_CH-1:0] one_shot_o,
    output logic [N_CH-1:0] grant_o,
    output logic            busy_o,
    output logic            to_30ms_o
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ1 = 3'd1,
        DLY1 = 3'd2,
        HALT = 3'd3,
        REQ2 = 3'd4,
        DLY2 = 3'd5
    } ch_state_t;

    ch_state_t        state_q [N_CH];
    ch_state_t        state_d [N_CH];
    logic [N_CH-1:0]  sw;
    logic [N_CH-1:0]  grant_q;
    logic [PTR_W-1:0] owner_q;
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] idx_w;
    logic             win_found;
    logic             grant_start;
    logic             expire;
    logic [N_CH-1:0]  win_onehot;

`ifdef DEBOUNCE_ARB_SYNC_EN
    logic [N_CH-1:0] sync_meta;
    logic [N_CH-1:0] sync_q;

    // Two-flop synchronizer per channel for asynchronous board switches
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= sw_noisy_i;
            sync_q    <= sync_meta;
        end
    end

    assign sw = sync_q;
`else
    assign sw = sw_noisy_i;
`endif

    assign grant_o     = grant_q;
    assign busy_o      = |grant_q;
    assign to_30ms_o   = busy_o && (count_q == CNT_W'(CNT_MAX - 1));
    assign expire      = to_30ms_o;
    assign grant_start = !busy_o && win_found;
    assign win_onehot  = {{(N_CH-1){1'b0}}, 1'b1} << win_idx;

    // Round-robin search: first requesting channel at or above ptr, with wrap
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_w     = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx_w = PTR_W'((int'(ptr_q) + k) % N_CH);
            if (!win_found && (state_q[idx_w] == REQ1 || state_q[idx_w] == REQ2)) begin
                win_found = 1'b1;
                win_idx   = idx_w;
            end
        end
    end

    // Timer ownership and round-robin pointer update
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else if (grant_start) begin
            grant_q <= win_onehot;
            owner_q <= win_idx;
        end else if (expire) begin
            grant_q <= '0;
            if (owner_q == PTR_W'(N_CH - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= owner_q + 1'b1;
            end
        end
    end

    // Shared delay counter: cleared on grant and on expiry, counts while busy
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            count_q <= '0;
        end else if (grant_start) begin
            count_q <= '0;
        end else if (busy_o) begin
            if (expire) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Per-channel debounce state registers
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Per-channel next state; switch level is ignored while requesting or timing
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: if (sw[i]) state_d[i] = REQ1;
                REQ1: if (grant_start && (win_idx == PTR_W'(i))) state_d[i] = DLY1;
                DLY1: if (expire && grant_q[i]) state_d[i] = HALT;
                HALT: if (!sw[i]) state_d[i] = REQ2;
                REQ2: if (grant_start && (win_idx == PTR_W'(i))) state_d[i] = DLY2;
                DLY2: if (expire && grant_q[i]) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Debounced level and press pulse decoded from each channel's state
    always_comb begin
        sw_clean_o = '0;
        one_shot_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            sw_clean_o[i] = (state_q[i] == HALT) || (state_q[i] == REQ2) ||
                            (state_q[i] == DLY2);
            one_shot_o[i] = to_30ms_o && (state_q[i] == DLY1);
        end
    end

endmodule
